// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle fetch/decode/execute controller for an RV32I subset
// (addi, add, beq, bne, ebreak). Optional illegal-instruction trap: SEQ_ILLEGAL_TRAP_EN.

module datapath_sequencer #(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic [PC_WIDTH-1:0] instr_addr,
   input  logic [31:0]         instr,
   input  logic                EQ,
   output logic [4:0]          AD1,
   output logic [4:0]          AD2,
   output logic [4:0]          AD3,
   output logic                WE3,
   output logic [31:0]         ImmOp,
   output logic                ALUsrc,
   output logic                ALUctrl,
   output logic                busy,
   output logic                halted,
   output logic                illegal
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      K_ADDI    = 3'd0,
      K_ADD     = 3'd1,
      K_BEQ     = 3'd2,
      K_BNE     = 3'd3,
      K_EBREAK  = 3'd4,
      K_ILLEGAL = 3'd5
   } kind_t;

   localparam logic [6:0]          OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0]          OPC_OP      = 7'b0110011;
   localparam logic [6:0]          OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0]          OPC_SYSTEM  = 7'b1110011;
   localparam logic [31:0]         EBREAK_WORD = 32'h0010_0073;
   localparam logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(3'd4);

   state_t               state_r;
   state_t               state_s;
   kind_t                kind_r;
   kind_t                dec_kind_s;
   logic [PC_WIDTH-1:0]  pc_r;
   logic [4:0]           ad1_r;
   logic [4:0]           ad2_r;
   logic [4:0]           ad3_r;
   logic                 we3_r;
   logic [31:0]          imm_r;
   logic                 alusrc_r;
   logic                 aluctrl_r;

   logic [6:0]           opcode_s;
   logic [2:0]           funct3_s;
   logic [6:0]           funct7_s;
   logic [4:0]           rd_s;
   logic [4:0]           rs1_s;
   logic [4:0]           rs2_s;
   logic [31:0]          i_imm_s;
   logic [31:0]          b_imm_s;
   logic                 start_ok_s;

   assign opcode_s = instr[6:0];
   assign rd_s     = instr[11:7];
   assign funct3_s = instr[14:12];
   assign rs1_s    = instr[19:15];
   assign rs2_s    = instr[24:20];
   assign funct7_s = instr[31:25];
   assign i_imm_s  = {{20{instr[31]}}, instr[31:20]};
   assign b_imm_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

   assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_HALT));

   // Classify the fetched word; a branch offset with bit 1 set is not 4-byte aligned.
   always_comb begin
      dec_kind_s = K_ILLEGAL;
      case (opcode_s)
         OPC_OP_IMM: begin
            if (funct3_s == 3'b000) dec_kind_s = K_ADDI;
            else                    dec_kind_s = K_ILLEGAL;
         end
         OPC_OP: begin
            if ((funct3_s == 3'b000) && (funct7_s == 7'b0000000)) dec_kind_s = K_ADD;
            else                                                  dec_kind_s = K_ILLEGAL;
         end
         OPC_BRANCH: begin
            if (instr[8])                dec_kind_s = K_ILLEGAL;
            else if (funct3_s == 3'b000) dec_kind_s = K_BEQ;
            else if (funct3_s == 3'b001) dec_kind_s = K_BNE;
            else                         dec_kind_s = K_ILLEGAL;
         end
         OPC_SYSTEM: begin
            if (instr == EBREAK_WORD) dec_kind_s = K_EBREAK;
            else                      dec_kind_s = K_ILLEGAL;
         end
         default: dec_kind_s = K_ILLEGAL;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_s;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_FETCH;
            else       state_s = ST_IDLE;
         end
         ST_FETCH:  state_s = ST_DECODE;
         ST_DECODE: begin
            if (dec_kind_s == K_EBREAK) begin
               state_s = ST_HALT;
            end else if (dec_kind_s == K_ILLEGAL) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
               state_s = ST_HALT;
`else
               state_s = ST_EXEC;
`endif
            end else begin
               state_s = ST_EXEC;
            end
         end
         ST_EXEC: state_s = ST_FETCH;
         ST_HALT: begin
            if (start) state_s = ST_FETCH;
            else       state_s = ST_HALT;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the state register.
   always_comb begin
      busy   = 1'b0;
      halted = 1'b0;
      case (state_r)
         ST_FETCH, ST_DECODE, ST_EXEC: busy = 1'b1;
         ST_HALT:                      halted = 1'b1;
         default: begin
            busy   = 1'b0;
            halted = 1'b0;
         end
      endcase
   end

   // PC and datapath control registers; controls load in DECODE and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r      <= {PC_WIDTH{1'b0}};
         kind_r    <= K_ADDI;
         ad1_r     <= 5'd0;
         ad2_r     <= 5'd0;
         ad3_r     <= 5'd0;
         we3_r     <= 1'b0;
         imm_r     <= 32'd0;
         alusrc_r  <= 1'b0;
         aluctrl_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_HALT: begin
               we3_r <= 1'b0;
               if (start_ok_s) pc_r <= RESET_PC;
            end
            ST_DECODE: begin
               kind_r <= dec_kind_s;
               case (dec_kind_s)
                  K_ADDI: begin
                     ad1_r     <= rs1_s;
                     ad3_r     <= rd_s;
                     imm_r     <= i_imm_s;
                     alusrc_r  <= 1'b1;
                     aluctrl_r <= 1'b0;
                     we3_r     <= (rd_s != 5'd0);
                  end
                  K_ADD: begin
                     ad1_r     <= rs1_s;
                     ad2_r     <= rs2_s;
                     ad3_r     <= rd_s;
                     alusrc_r  <= 1'b0;
                     aluctrl_r <= 1'b0;
                     we3_r     <= (rd_s != 5'd0);
                  end
                  K_BEQ, K_BNE: begin
                     ad1_r     <= rs1_s;
                     ad2_r     <= rs2_s;
                     imm_r     <= b_imm_s;
                     alusrc_r  <= 1'b0;
                     aluctrl_r <= 1'b1;
                     we3_r     <= 1'b0;
                  end
                  default: we3_r <= 1'b0;
               endcase
            end
            ST_EXEC: begin
               we3_r <= 1'b0;
               case (kind_r)
                  K_BEQ: begin
                     if (EQ) pc_r <= pc_r + PC_WIDTH'(imm_r);
                     else    pc_r <= pc_r + PC_STEP;
                  end
                  K_BNE: begin
                     if (!EQ) pc_r <= pc_r + PC_WIDTH'(imm_r);
                     else     pc_r <= pc_r + PC_STEP;
                  end
                  default: pc_r <= pc_r + PC_STEP;
               endcase
            end
            default: we3_r <= 1'b0;
         endcase
      end
   end

`ifdef SEQ_ILLEGAL_TRAP_EN
   logic illegal_r;

   // Sticky trap flag, cleared when a new run starts.
   always_ff @(posedge clk) begin
      if (rst)                                                   illegal_r <= 1'b0;
      else if ((state_r == ST_DECODE) && (dec_kind_s == K_ILLEGAL)) illegal_r <= 1'b1;
      else if (start_ok_s)                                       illegal_r <= 1'b0;
      else                                                       illegal_r <= illegal_r;
   end

   assign illegal = illegal_r;
`else
   assign illegal = 1'b0;
`endif

   assign instr_addr = pc_r;
   assign AD1        = ad1_r;
   assign AD2        = ad2_r;
   assign AD3        = ad3_r;
   assign WE3        = we3_r;
   assign ImmOp      = imm_r;
   assign ALUsrc     = alusrc_r;
   assign ALUctrl    = aluctrl_r;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed programs plus random programs checked against an
// instruction-level reference model; a small register file / comparator closes the EQ loop.

module tb_datapath_sequencer;

   localparam int K_ADDI = 0, K_ADD = 1, K_BR = 2, K_NOP = 3, K_HALT = 4, K_TRAP = 5;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef struct {
      logic [31:0] pc;
      int          kind;
      logic [4:0]  ad1, ad2, ad3;
      logic [31:0] imm;
      logic        we;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst, start, EQ, WE3, ALUsrc, ALUctrl, busy, halted, illegal;
   logic [31:0] instr_addr, instr, ImmOp;
   logic [4:0]  AD1, AD2, AD3;

   logic [31:0] mem [0:63];
   logic [31:0] rf [0:31];
   logic [31:0] iss_rf [0:31];
   logic        rf_clr;
   logic [31:0] op_a, op_b;
   rec_t        exp_q [$];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   datapath_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .start(start), .instr_addr(instr_addr), .instr(instr), .EQ(EQ),
      .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .ImmOp(ImmOp), .ALUsrc(ALUsrc),
      .ALUctrl(ALUctrl), .busy(busy), .halted(halted), .illegal(illegal)
   );

   // Datapath stand-in: synchronous instruction memory, register file, ALU comparator.
   assign op_a = rf[AD1];
   assign op_b = ALUsrc ? ImmOp : rf[AD2];
   assign EQ   = (op_a == op_b);

   always @(posedge clk) instr <= mem[instr_addr[7:2]];

   always @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      end else if (WE3) begin
         rf[AD3] <= ALUctrl ? (op_a - op_b) : (op_a + op_b);
      end
   end

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
      return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = EBREAK;
   endtask

   // Instruction-level reference: executes the program and lists what each EXEC/HALT must show.
   task automatic run_iss();
      logic [31:0] pc, w;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      int          bimm;
      bit          taken, done;
      rec_t        r;
      exp_q.delete();
      for (int i = 0; i < 32; i++) iss_rf[i] = 32'h0;
      pc = 32'h0;
      done = 1'b0;
      for (int s = 0; s < 2000 && !done; s++) begin
         w   = mem[pc[7:2]];
         rd  = w[11:7];
         f3  = w[14:12];
         rs1 = w[19:15];
         rs2 = w[24:20];
         r.pc = pc; r.ad1 = rs1; r.ad2 = rs2; r.ad3 = rd; r.imm = 32'h0; r.we = 1'b0;
         if (w == EBREAK) begin
            r.kind = K_HALT;
            done = 1'b1;
         end else if (w[6:0] == 7'h13 && f3 == 3'd0) begin
            r.kind = K_ADDI;
            r.imm  = $signed(w) >>> 20;
            r.we   = (rd != 5'd0);
            if (rd != 5'd0) iss_rf[rd] = iss_rf[rs1] + r.imm;
            pc = pc + 32'd4;
         end else if (w[6:0] == 7'h33 && f3 == 3'd0 && w[31:25] == 7'd0) begin
            r.kind = K_ADD;
            r.we   = (rd != 5'd0);
            if (rd != 5'd0) iss_rf[rd] = iss_rf[rs1] + iss_rf[rs2];
            pc = pc + 32'd4;
         end else if (w[6:0] == 7'h63 && f3 < 3'd2 && !w[8]) begin
            r.kind = K_BR;
            bimm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            r.imm = bimm;
            taken = (f3 == 3'd0) ? (iss_rf[rs1] == iss_rf[rs2]) : (iss_rf[rs1] != iss_rf[rs2]);
            pc = taken ? pc + r.imm : pc + 32'd4;
         end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            r.kind = K_TRAP;
            done = 1'b1;
`else
            r.kind = K_NOP;
            pc = pc + 32'd4;
`endif
         end
         exp_q.push_back(r);
      end
   endtask

   // Start the loaded program and follow it instruction by instruction (3 cycles each).
   task automatic run_prog(input string name);
      rec_t r;
      run_iss();
      rf_clr = 1'b1;
      @(posedge clk); #1;
      rf_clr = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      foreach (exp_q[k]) begin
         r = exp_q[k];
         chk32({name, ".fetch_addr"}, instr_addr, r.pc);
         chk1({name, ".fetch_busy"}, busy, 1'b1);
         chk1({name, ".fetch_we3"}, WE3, 1'b0);
         chk1({name, ".fetch_illegal"}, illegal, 1'b0);
         start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk1({name, ".decode_we3"}, WE3, 1'b0);
         start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (r.kind == K_HALT || r.kind == K_TRAP) begin
            start = 1'b0;
            chk1({name, ".halted"}, halted, 1'b1);
            chk1({name, ".halt_busy"}, busy, 1'b0);
            chk32({name, ".halt_addr"}, instr_addr, r.pc);
            chk1({name, ".halt_we3"}, WE3, 1'b0);
            chk1({name, ".illegal"}, illegal, (r.kind == K_TRAP));
         end else begin
            chk1({name, ".exec_we3"}, WE3, r.we);
            chk1({name, ".exec_busy"}, busy, 1'b1);
            if (r.kind != K_NOP) begin
               chk32({name, ".exec_ad1"}, {27'd0, AD1}, {27'd0, r.ad1});
               chk1({name, ".exec_alusrc"}, ALUsrc, (r.kind == K_ADDI));
               chk1({name, ".exec_aluctrl"}, ALUctrl, (r.kind == K_BR));
            end
            if (r.kind == K_ADD || r.kind == K_BR) chk32({name, ".exec_ad2"}, {27'd0, AD2}, {27'd0, r.ad2});
            if (r.kind == K_ADD || r.kind == K_ADDI) chk32({name, ".exec_ad3"}, {27'd0, AD3}, {27'd0, r.ad3});
            if (r.kind == K_ADDI || r.kind == K_BR) chk32({name, ".exec_imm"}, ImmOp, r.imm);
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      for (int i = 0; i < 32; i++) chk32($sformatf("%s.x%0d", name, i), rf[i], iss_rf[i]);
   endtask

   task automatic gen_random(input int len);
      int          sel, k;
      logic [4:0]  rd, rs1, rs2;
      clear_mem();
      for (int i = 0; i < len; i++) begin
         sel = $urandom_range(0, 9);
         rd  = 5'($urandom_range(0, 7));
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         k   = $urandom_range(1, len - i);
         case (sel)
            0, 1, 2, 3: mem[i] = enc_i(12'($urandom_range(0, 4095)), rs1, rd);
            4, 5:       mem[i] = enc_r(7'd0, rs2, rs1, rd);
            6, 7:       mem[i] = enc_b(13'(k * 4), rs2, rs1, 3'($urandom_range(0, 1)));
            8: begin
               case ($urandom_range(0, 3))
                  0:       mem[i] = 32'hFFFF_FFFF;
                  1:       mem[i] = enc_r(7'h20, rs2, rs1, rd);
                  2:       mem[i] = enc_b(13'd6, rs2, rs1, 3'b000);
                  default: mem[i] = enc_b(13'd8, rs2, rs1, 3'b100);
               endcase
            end
            default:    mem[i] = enc_i(12'($urandom_range(0, 31)), rs1, 5'd0);
         endcase
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b1;
      rf_clr = 1'b0;
      clear_mem();

      // Reset dominates start.
      repeat (2) @(posedge clk);
      #1;
      chk32("reset.instr_addr", instr_addr, 32'h0);
      chk32("reset.imm", ImmOp, 32'h0);
      chk32("reset.ad", {17'd0, AD1, AD2, AD3}, 32'h0);
      chk1("reset.we3", WE3, 1'b0);
      chk1("reset.alusrc", ALUsrc, 1'b0);
      chk1("reset.aluctrl", ALUctrl, 1'b0);
      chk1("reset.busy", busy, 1'b0);
      chk1("reset.halted", halted, 1'b0);
      chk1("reset.illegal", illegal, 1'b0);
      rst = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      chk1("idle.busy", busy, 1'b0);
      chk1("idle.halted", halted, 1'b0);

      mem[0] = 32'h0050_0093;
      run_prog("addi5");

      clear_mem();
      mem[0] = 32'h0070_0013;
      run_prog("addi_x0");

      clear_mem();
      mem[0] = 32'h0030_0093;
      mem[1] = 32'hFFF0_8093;
      mem[2] = 32'hFE00_9EE3;
      run_prog("loop");

      clear_mem();
      mem[0] = 32'hFFFF_FFFF;
      run_prog("illegal");

      // Reset during an EXEC that writes.
      clear_mem();
      mem[0] = 32'h0050_0093;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_exec.we3_before", WE3, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk1("rst_exec.we3_after", WE3, 1'b0);
      chk1("rst_exec.busy", busy, 1'b0);
      chk1("rst_exec.halted", halted, 1'b0);
      chk32("rst_exec.instr_addr", instr_addr, 32'h0);
      chk32("rst_exec.imm", ImmOp, 32'h0);
      run_prog("restart");

      for (int t = 0; t < 25; t++) begin
         gen_random($urandom_range(4, 12));
         run_prog($sformatf("rand%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
